// File: rtl/systolic_matmul_stream.sv
// systolic_matmul_stream
//   Fixed-point systolic matrix multiplier: C = A*B, or C = C_prev + A*B when
//   accum is sampled high with start. Dimensions are chosen at run time, up to
//   M_MAX x N_MAX x K_MAX. A and B are written element by element while the
//   block is in LOAD. A skewed MxN PE grid then accumulates the dot products.
//   The results are rounded half-up, optionally added to the retained C
//   buffer, and saturated. C is then streamed out row-major under valid/ready.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, accum          begin an operation (IDLE only), accumulate select
//   m_dim, n_dim, k_dim   runtime dimensions, sampled with start
//   a_data/a_row/a_col/a_valid   A element write port
//   b_data/b_row/b_col/b_valid   B element write port
//   c_data/c_row/c_col/c_valid   C element output (registered, held until accepted)
//   c_ready               consumer accepts the presented C element
//   busy                  high in every state except IDLE
//   done                  one-cycle completion pulse
//   err                   sticky illegal-dimension / out-of-range-index flag
module systolic_matmul_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int M_MAX      = 8,
  parameter int N_MAX      = 8,
  parameter int K_MAX      = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       accum,
  input  logic [$clog2(M_MAX+1)-1:0] m_dim,
  input  logic [$clog2(N_MAX+1)-1:0] n_dim,
  input  logic [$clog2(K_MAX+1)-1:0] k_dim,
  input  logic [DATA_WIDTH-1:0]      a_data,
  input  logic [$clog2(M_MAX)-1:0]   a_row,
  input  logic [$clog2(K_MAX)-1:0]   a_col,
  input  logic                       a_valid,
  input  logic [DATA_WIDTH-1:0]      b_data,
  input  logic [$clog2(K_MAX)-1:0]   b_row,
  input  logic [$clog2(N_MAX)-1:0]   b_col,
  input  logic                       b_valid,
  output logic [DATA_WIDTH-1:0]      c_data,
  output logic [$clog2(M_MAX)-1:0]   c_row,
  output logic [$clog2(N_MAX)-1:0]   c_col,
  output logic                       c_valid,
  input  logic                       c_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int MDW = $clog2(M_MAX+1);
  localparam int NDW = $clog2(N_MAX+1);
  localparam int KDW = $clog2(K_MAX+1);
  localparam int MIW = $clog2(M_MAX);
  localparam int NIW = $clog2(N_MAX);
  localparam int KIW = $clog2(K_MAX);
  localparam int TW  = 8;   // compute-cycle counter, holds up to M_MAX+N_MAX+K_MAX
  localparam int CW  = 16;  // load beat counters
  localparam int PW  = 2*DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic signed [ACC_WIDTH:0] RND =
    {{(ACC_WIDTH-FRAC_WIDTH+1){1'b0}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Round half up, then drop the fractional bits of the product scale.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH:0] s;
    s = {acc[ACC_WIDTH-1], acc};
    round_shift = (s + RND) >>> FRAC_WIDTH;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH:0] v);
    if (v > SAT_MAX)
      saturate = SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN)
      saturate = SAT_MIN[DATA_WIDTH-1:0];
    else
      saturate = v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] post_proc(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic                         use_prev,
    input logic signed [DATA_WIDTH-1:0] prev);
    logic signed [ACC_WIDTH:0] r;
    r = round_shift(acc);
    if (use_prev)
      r = r + {{(ACC_WIDTH+1-DATA_WIDTH){prev[DATA_WIDTH-1]}}, prev};
    post_proc = saturate(r);
  endfunction

  // Control registers
  logic [1:0]                   r_state;
  logic [MDW-1:0]               r_m;
  logic [NDW-1:0]               r_n;
  logic [KDW-1:0]               r_k;
  logic                         r_accum;
  logic [CW-1:0]                r_a_cnt;
  logic [CW-1:0]                r_b_cnt;
  logic [TW-1:0]                r_t;
  logic                         r_first;
  logic                         r_err;
  logic                         r_done;
  logic                         r_cv;
  logic signed [DATA_WIDTH-1:0] r_cd;
  logic [MIW-1:0]               r_cr;
  logic [NIW-1:0]               r_cc;

  // Operand buffers, PE grid and retained result buffer
  logic signed [DATA_WIDTH-1:0] r_a    [M_MAX][K_MAX];
  logic signed [DATA_WIDTH-1:0] r_b    [K_MAX][N_MAX];
  logic signed [DATA_WIDTH-1:0] r_ap   [M_MAX][N_MAX];
  logic signed [DATA_WIDTH-1:0] r_bp   [M_MAX][N_MAX];
  logic signed [ACC_WIDTH-1:0]  r_acc  [M_MAX][N_MAX];
  logic signed [DATA_WIDTH-1:0] r_cbuf [M_MAX][N_MAX];

  logic signed [DATA_WIDTH-1:0] w_a_edge [M_MAX];
  logic signed [DATA_WIDTH-1:0] w_b_edge [N_MAX];
  logic signed [DATA_WIDTH-1:0] w_ain    [M_MAX][N_MAX];
  logic signed [DATA_WIDTH-1:0] w_bin    [M_MAX][N_MAX];
  logic signed [PW-1:0]         w_prod   [M_MAX][N_MAX];
  logic signed [ACC_WIDTH-1:0]  w_prod_x [M_MAX][N_MAX];
  logic signed [DATA_WIDTH-1:0] w_post   [M_MAX][N_MAX];

  logic           w_dims_ok;
  logic           w_a_in;
  logic           w_b_in;
  logic           w_load_done;
  logic           w_t_last;
  logic           w_row_end;
  logic           w_last_el;
  logic [MIW-1:0] w_nr;
  logic [NIW-1:0] w_nc;

  assign w_dims_ok = (m_dim != '0) && (m_dim <= MDW'(M_MAX)) &&
                     (n_dim != '0) && (n_dim <= NDW'(N_MAX)) &&
                     (k_dim != '0) && (k_dim <= KDW'(K_MAX));
  assign w_a_in      = (MDW'(a_row) < r_m) && (KDW'(a_col) < r_k);
  assign w_b_in      = (KDW'(b_row) < r_k) && (NDW'(b_col) < r_n);
  assign w_load_done = (r_a_cnt >= CW'(r_m) * CW'(r_k)) &&
                       (r_b_cnt >= CW'(r_n) * CW'(r_k));
  assign w_t_last    = (r_t == TW'(r_m) + TW'(r_n) + TW'(r_k) - TW'(3));
  assign w_row_end   = (NDW'(r_cc) == r_n - NDW'(1));
  assign w_last_el   = w_row_end && (MDW'(r_cr) == r_m - MDW'(1));
  assign w_nr        = r_cr + MIW'(1);
  assign w_nc        = r_cc + NIW'(1);

  // Skewed injection at the grid edges: row i of A enters i cycles late and
  // column j of B enters j cycles late. Out-of-range slots inject zero, so
  // PEs outside the runtime dims never accumulate anything.
  always_comb begin
    logic [TW-1:0] idx;
    for (int i = 0; i < M_MAX; i++) begin
      idx = r_t - TW'(i);
      w_a_edge[i] = '0;
      if ((TW'(i) < TW'(r_m)) && (r_t >= TW'(i)) && (idx < TW'(r_k)))
        w_a_edge[i] = r_a[i][idx[KIW-1:0]];
    end
    for (int j = 0; j < N_MAX; j++) begin
      idx = r_t - TW'(j);
      w_b_edge[j] = '0;
      if ((TW'(j) < TW'(r_n)) && (r_t >= TW'(j)) && (idx < TW'(r_k)))
        w_b_edge[j] = r_b[idx[KIW-1:0]][j];
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < M_MAX; gi++) begin : g_row
      for (gj = 0; gj < N_MAX; gj++) begin : g_col
        if (gj == 0) begin : g_aedge
          assign w_ain[gi][gj] = w_a_edge[gi];
        end else begin : g_ain
          assign w_ain[gi][gj] = r_ap[gi][gj-1];
        end
        if (gi == 0) begin : g_bedge
          assign w_bin[gi][gj] = w_b_edge[gj];
        end else begin : g_bin
          assign w_bin[gi][gj] = r_bp[gi-1][gj];
        end
        assign w_prod[gi][gj]   = w_ain[gi][gj] * w_bin[gi][gj];
        assign w_prod_x[gi][gj] = {{(ACC_WIDTH-PW){w_prod[gi][gj][PW-1]}}, w_prod[gi][gj]};
        assign w_post[gi][gj]   = post_proc(r_acc[gi][gj], r_accum, r_cbuf[gi][gj]);
      end
    end
  endgenerate

  // Datapath: operand capture, PE grid, result buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M_MAX; i++)
        for (int k = 0; k < K_MAX; k++)
          r_a[i][k] <= '0;
      for (int k = 0; k < K_MAX; k++)
        for (int j = 0; j < N_MAX; j++)
          r_b[k][j] <= '0;
      for (int i = 0; i < M_MAX; i++)
        for (int j = 0; j < N_MAX; j++) begin
          r_ap[i][j]   <= '0;
          r_bp[i][j]   <= '0;
          r_acc[i][j]  <= '0;
          r_cbuf[i][j] <= '0;
        end
    end else begin
      if (r_state == S_LOAD) begin
        if (a_valid && w_a_in) r_a[a_row][a_col] <= a_data;
        if (b_valid && w_b_in) r_b[b_row][b_col] <= b_data;
      end
      for (int i = 0; i < M_MAX; i++)
        for (int j = 0; j < N_MAX; j++) begin
          if (r_state == S_COMP) begin
            r_ap[i][j]  <= w_ain[i][j];
            r_bp[i][j]  <= w_bin[i][j];
            r_acc[i][j] <= r_acc[i][j] + w_prod_x[i][j];
          end else if (r_state == S_LOAD) begin
            r_ap[i][j]  <= '0;
            r_bp[i][j]  <= '0;
            r_acc[i][j] <= '0;
          end
          // Whole grid post-processed at once on the first DRAIN cycle;
          // cells outside the current dims are stored as zero.
          if ((r_state == S_DRAIN) && r_first)
            r_cbuf[i][j] <= ((i < int'(r_m)) && (j < int'(r_n))) ? w_post[i][j] : '0;
        end
    end
  end

  // Control FSM and output stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_accum <= 1'b0;
      r_a_cnt <= '0;
      r_b_cnt <= '0;
      r_t     <= '0;
      r_first <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_cv    <= 1'b0;
      r_cd    <= '0;
      r_cr    <= '0;
      r_cc    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_dims_ok) begin
              r_m     <= m_dim;
              r_n     <= n_dim;
              r_k     <= k_dim;
              r_accum <= accum;
              r_err   <= 1'b0;
              r_a_cnt <= '0;
              r_b_cnt <= '0;
              r_state <= S_LOAD;
            end else begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (a_valid) begin
            if (w_a_in) r_a_cnt <= r_a_cnt + CW'(1);
            else        r_err   <= 1'b1;
          end
          if (b_valid) begin
            if (w_b_in) r_b_cnt <= r_b_cnt + CW'(1);
            else        r_err   <= 1'b1;
          end
          if (w_load_done) begin
            r_t     <= '0;
            r_state <= S_COMP;
          end
        end
        S_COMP: begin
          if (w_t_last) begin
            r_first <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_t <= r_t + TW'(1);
          end
        end
        default: begin
          // (0,0) comes straight from the post-processor since the buffer
          // is only being written on this cycle.
          if (r_first) begin
            r_first <= 1'b0;
            r_cv    <= 1'b1;
            r_cd    <= w_post[0][0];
            r_cr    <= '0;
            r_cc    <= '0;
          end else if (r_cv && c_ready) begin
            if (w_last_el) begin
              r_cv    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_row_end) begin
              r_cr <= w_nr;
              r_cc <= '0;
              r_cd <= r_cbuf[w_nr][0];
            end else begin
              r_cc <= w_nc;
              r_cd <= r_cbuf[r_cr][w_nc];
            end
          end
        end
      endcase
    end
  end

  assign c_data  = r_cd;
  assign c_row   = r_cr;
  assign c_col   = r_cc;
  assign c_valid = r_cv;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Testbench for systolic_matmul_stream: directed vectors with hand-derived
// results; a scoreboard queue is filled by the stimulus and drained by a
// monitor that compares every accepted C element.
module tb_systolic_matmul_stream;

  logic        clk = 1'b0;
  logic        rst, start, accum;
  logic [3:0]  m_dim, n_dim, k_dim;
  logic [15:0] a_data, b_data;
  logic [2:0]  a_row, a_col, b_row, b_col;
  logic        a_valid, b_valid;
  logic [15:0] c_data;
  logic [2:0]  c_row, c_col;
  logic        c_valid, c_ready, busy, done, err;

  systolic_matmul_stream dut (
    .clk(clk), .rst(rst), .start(start), .accum(accum),
    .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
    .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_valid(a_valid),
    .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_valid(b_valid),
    .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_valid(c_valid),
    .c_ready(c_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] tb_a[8][8];
  logic [15:0] tb_b[8][8];
  logic        bp_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int r, input int c);
    exp_t e;
    e.d = 16'(d);
    e.r = 3'(r);
    e.c = 3'(c);
    sb_q.push_back(e);
  endtask

  task automatic push_all(input int m, input int n, input int d);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        push(d, i, j);
  endtask

  task automatic fill(input logic [15:0] av, input logic [15:0] bv);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        tb_a[i][j] = av;
        tb_b[i][j] = bv;
      end
  endtask

  // Monitor: compare each accepted element; while stalled, the presented
  // element must not change.
  logic held_v = 1'b0;
  exp_t held, got;
  always @(negedge clk) begin
    if (!rst) begin
      if (held_v) begin
        chk("hold_valid", 32'(c_valid), 32'd1);
        chk("hold_data", 32'(c_data), 32'(held.d));
        chk("hold_index", 32'({c_row, c_col}), 32'({held.r, held.c}));
      end
      held_v = 1'b0;
      if (c_valid && c_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'(c_data), 32'hDEAD);
        end else begin
          got = sb_q.pop_front();
          chk("c_data", 32'(c_data), 32'(got.d));
          chk("c_row", 32'(c_row), 32'(got.r));
          chk("c_col", 32'(c_col), 32'(got.c));
        end
      end else if (c_valid) begin
        held_v = 1'b1;
        held.d = c_data;
        held.r = c_row;
        held.c = c_col;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    c_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      c_ready = bp_mode ? ~c_ready : 1'b1;
    end
  end

  task automatic start_op(input int m, input int n, input int k, input logic acc);
    start = 1'b1;
    m_dim = 4'(m);
    n_dim = 4'(n);
    k_dim = 4'(k);
    accum = acc;
    tick();
    start = 1'b0;
  endtask

  task automatic load_op(input int m, input int n, input int k);
    int nb;
    nb = (m > n) ? m*k : n*k;
    for (int p = 0; p < nb; p++) begin
      a_valid = (p < m*k);
      b_valid = (p < n*k);
      if (p < m*k) begin
        a_row  = 3'(p / k);
        a_col  = 3'(p % k);
        a_data = tb_a[p / k][p % k];
      end
      if (p < n*k) begin
        b_row  = 3'(p / n);
        b_col  = 3'(p % n);
        b_data = tb_b[p / n][p % n];
      end
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain(input int mn, input logic chk_beats, input logic exp_err);
    int   beats;
    logic seen;
    beats = 0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (c_valid) begin
        seen = 1'b1;
        beats++;
      end else if (seen) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("err_at_done", 32'(err), 32'(exp_err));
        if (chk_beats) chk("drain_beats", 32'(beats), 32'(mn));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        return;
      end
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int m, input int n, input int k, input logic acc);
    start_op(m, n, k, acc);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared_by_start", 32'(err), 32'd0);
    load_op(m, n, k);
    wait_drain(m*n, !bp_mode, 1'b0);
  endtask

  initial begin
    logic saw;
    rst = 1'b1; start = 1'b0; accum = 1'b0;
    m_dim = '0; n_dim = '0; k_dim = '0;
    a_data = '0; b_data = '0; a_row = '0; a_col = '0; b_row = '0; b_col = '0;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();
    chk("rst_c_valid", 32'(c_valid), 32'd0);
    chk("rst_c_data", 32'(c_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // T1: 5x5x5, A = 1.0..25.0, B = I
    fill(16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) tb_a[i][j] = 16'((i*5 + j + 1) * 256);
      tb_b[i][i] = 16'h0100;
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        push((i*5 + j + 1) * 256, i, j);
    run_op(5, 5, 5, 1'b0);

    // T3: rounding
    fill(16'h0001, 16'h0080);
    push(16'h0001, 0, 0);
    run_op(1, 1, 1, 1'b0);
    fill(16'hFFFF, 16'h0080);
    push(16'h0000, 0, 0);
    run_op(1, 1, 1, 1'b0);

    // T4: saturation both ways
    fill(16'h6400, 16'h6400);
    push_all(2, 2, 16'h7FFF);
    run_op(2, 2, 2, 1'b0);
    fill(16'h9C00, 16'h6400);
    push_all(2, 2, 16'h8000);
    run_op(2, 2, 2, 1'b0);

    // T6a: T1 data again under alternating c_ready
    fill(16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) tb_a[i][j] = 16'((i*5 + j + 1) * 256);
      tb_b[i][i] = 16'h0100;
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        push((i*5 + j + 1) * 256, i, j);
    bp_mode = 1'b1;
    run_op(5, 5, 5, 1'b0);
    bp_mode = 1'b0;
    tick();

    // T2: 3x4x2, 2.0 * 3.0 summed twice = 12.0
    fill(16'h0200, 16'h0300);
    push_all(3, 4, 16'h0C00);
    run_op(3, 4, 2, 1'b0);

    // T5: accumulate the same product onto the retained 12.0 -> 24.0
    push_all(3, 4, 16'h1800);
    run_op(3, 4, 2, 1'b1);

    // T6b: reset in the middle of COMPUTE
    fill(16'h0100, 16'h0100);
    start_op(8, 8, 8, 1'b0);
    load_op(8, 8, 8);
    repeat (4) tick();
    chk("busy_in_compute", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_c_valid", 32'(c_valid), 32'd0);
    chk("abort_c_data", 32'(c_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // T5b: accumulate after reset sees an empty C buffer -> 12.0
    fill(16'h0200, 16'h0300);
    push_all(3, 4, 16'h0C00);
    run_op(3, 4, 2, 1'b1);

    // T6c: k_dim = 0 is rejected
    start_op(2, 2, 0, 1'b0);
    chk("kdim0_done", 32'(done), 32'd1);
    chk("kdim0_err", 32'(err), 32'd1);
    chk("kdim0_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c_valid || busy || done) saw = 1'b1;
    end
    chk("kdim0_no_drain", 32'(saw), 32'd0);

    // T6d: out-of-range A row is ignored and flags err
    start_op(2, 2, 1, 1'b0);
    chk("row_err_cleared", 32'(err), 32'd0);
    a_valid = 1'b1; a_row = 3'd3; a_col = 3'd0; a_data = 16'h7777;
    tick();
    a_valid = 1'b0;
    chk("bad_row_err", 32'(err), 32'd1);
    a_valid = 1'b1; a_row = 3'd0; a_col = 3'd0; a_data = 16'h0100;
    b_valid = 1'b1; b_row = 3'd0; b_col = 3'd0; b_data = 16'h0300;
    tick();
    a_valid = 1'b0;
    b_col = 3'd1; b_data = 16'h0400;
    tick();
    b_valid = 1'b0;
    repeat (8) tick();
    chk("bad_beat_not_counted", 32'({busy, c_valid}), 32'b10);
    push(16'h0300, 0, 0);
    push(16'h0400, 0, 1);
    push(16'h0600, 1, 0);
    push(16'h0800, 1, 1);
    a_valid = 1'b1; a_row = 3'd1; a_col = 3'd0; a_data = 16'h0200;
    tick();
    a_valid = 1'b0;
    wait_drain(4, 1'b1, 1'b1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
